// File: rtl/display_shift_ctrl_pkg.sv
// Shared definitions for the serial display scheduler: FSM states,
// serial clock divider computation and parameter sanity check.
package display_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_LATCH,
    ST_GAP
  } state_t;

  function automatic int unsigned calc_half_div(input int unsigned sys_clk_hz,
                                                input int unsigned shift_clk_hz);
    int unsigned div;
    div = (shift_clk_hz == 0) ? 0 : sys_clk_hz / (2 * shift_clk_hz);
    return (div == 0) ? 1 : div;
  endfunction

  function automatic bit params_ok(input int unsigned sys_clk_hz,
                                   input int unsigned shift_clk_hz,
                                   input int unsigned shift_width);
    return (shift_clk_hz != 0) && (sys_clk_hz >= 2 * shift_clk_hz) && (shift_width >= 2);
  endfunction

endpackage

// File: rtl/display_shift_ctrl_tick.sv
// Restartable phase divider: o_tick on the last of HALF_DIV counts.
module shift_tick_gen
  import display_shift_ctrl_pkg::*;
#(
  parameter int unsigned HALF_DIV = 25
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_restart || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_shift_ctrl.sv
// Serial display scheduler: buffers one frame, shifts it MSB-first on a
// divided serial clock and pulses the storage latch.
module display_shift_ctrl
  import display_shift_ctrl_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ   = 50_000_000,
  parameter int unsigned SHIFT_CLK_HZ = 1_000_000,
  parameter int unsigned SHIFT_WIDTH  = 48
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic                   i_data_valid,
  input  logic [SHIFT_WIDTH-1:0] i_data,
  output logic                   o_data_ready,
  output logic                   o_serial_data,
  output logic                   o_serial_clk,
  output logic                   o_serial_latch,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned HALF_DIV = calc_half_div(SYS_CLK_HZ, SHIFT_CLK_HZ);
  localparam int unsigned BW       = $clog2(SHIFT_WIDTH);

  if (!params_ok(SYS_CLK_HZ, SHIFT_CLK_HZ, SHIFT_WIDTH)) begin : g_param_check
    $error("display_shift_ctrl: need SYS_CLK_HZ >= 2*SHIFT_CLK_HZ and SHIFT_WIDTH >= 2");
  end

  state_t                 state;
  logic [SHIFT_WIDTH-1:0] buffer;
  logic [SHIFT_WIDTH-1:0] shreg;
  logic [BW-1:0]          bitcnt;
  logic                   pending;
  logic                   tick;
  logic                   restart;

  // Holding the divider in IDLE/LOAD starts every timed state at count 0.
  assign restart       = (state == ST_IDLE) || (state == ST_LOAD);
  assign o_data_ready  = !pending;
  assign o_serial_data = shreg[SHIFT_WIDTH-1];

  shift_tick_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (restart),
    .o_tick    (tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      buffer         <= '0;
      shreg          <= '0;
      bitcnt         <= '0;
      pending        <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_done <= 1'b0;

      if (i_data_valid && !pending) begin
        buffer  <= i_data;
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pending && i_en) begin
            state  <= ST_LOAD;
            o_busy <= 1'b1;
          end
        end

        ST_LOAD: begin
          shreg        <= buffer;
          pending      <= 1'b0;
          bitcnt       <= BW'(SHIFT_WIDTH - 1);
          o_serial_clk <= 1'b0;
          state        <= ST_CLK_LO;
        end

        ST_CLK_LO: begin
          if (tick) begin
            o_serial_clk <= 1'b1;
            state        <= ST_CLK_HI;
          end
        end

        ST_CLK_HI: begin
          if (tick) begin
            o_serial_clk <= 1'b0;
            if (bitcnt == '0) begin
              o_serial_latch <= 1'b1;
              state          <= ST_LATCH;
            end else begin
              // Shift on the falling edge so data settles a full phase before the rise.
              shreg  <= {shreg[SHIFT_WIDTH-2:0], 1'b0};
              bitcnt <= bitcnt - BW'(1);
              state  <= ST_CLK_LO;
            end
          end
        end

        ST_LATCH: begin
          if (tick) begin
            o_serial_latch <= 1'b0;
            state          <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tick) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_shift_ctrl.sv
// Bench for display_shift_ctrl: emulates the shift-register chain and checks
// latched frames against a queue of accepted frames and the timing rules.
module tb_display_shift_ctrl;

  localparam int unsigned W    = 48;
  localparam int unsigned H    = 50_000_000 / (2 * 1_000_000);
  localparam int unsigned LAT  = 1 + (2 * W + 2) * H;
  localparam int unsigned H8   = 4 / (2 * 1);
  localparam int unsigned LAT8 = 1 + (2 * 8 + 2) * H8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] data = '0;
  logic         ready, sdata, sclk, latch, busy, done;

  logic         valid8 = 1'b0;
  logic [7:0]   data8 = '0;
  logic         ready8, sdata8, sclk8, latch8, busy8, done8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  display_shift_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_en           (en),
    .i_data_valid   (valid),
    .i_data         (data),
    .o_data_ready   (ready),
    .o_serial_data  (sdata),
    .o_serial_clk   (sclk),
    .o_serial_latch (latch),
    .o_busy         (busy),
    .o_done         (done)
  );

  display_shift_ctrl #(
    .SYS_CLK_HZ   (4),
    .SHIFT_CLK_HZ (1),
    .SHIFT_WIDTH  (8)
  ) dut8 (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_en           (1'b1),
    .i_data_valid   (valid8),
    .i_data         (data8),
    .o_data_ready   (ready8),
    .o_serial_data  (sdata8),
    .o_serial_clk   (sclk8),
    .o_serial_latch (latch8),
    .o_busy         (busy8),
    .o_done         (done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted frames in order; each must appear on the chain outputs.
  logic [W-1:0] exp_q[$];
  int           n_acc = 0;

  logic [W-1:0] cap;
  int           rises = 0, lat_len = 0, stab = 0, t0 = 0, cyc = 0, frames = 0;
  logic         p_sclk = 1'b0, p_lat = 1'b0, p_busy = 1'b0, p_sdata = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cap = '0; rises = 0; lat_len = 0; stab = 0;
      p_sclk = 1'b0; p_lat = 1'b0; p_busy = 1'b0; p_sdata = 1'b0;
    end else begin
      if (sdata !== p_sdata) begin
        check("data_moves_only_clk_low", sclk, 1'b0);
        stab = 0;
      end else begin
        stab++;
      end
      if (sclk && !p_sclk) begin
        check("data_setup", 64'(stab >= int'(H)), 1);
        cap = {cap[W-2:0], sdata};
        rises++;
      end
      if (latch && !p_lat) begin
        lat_len = 1;
        frames++;
        check("latch_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("latch_capture", cap, exp_q.pop_front());
      end else if (latch) begin
        lat_len++;
      end
      if (!latch && p_lat) check("latch_width", lat_len, H);
      if (busy && !p_busy) t0 = cyc;
      if (done) begin
        check("load_to_done", cyc - t0, LAT);
        check("clk_rises_per_frame", rises, W);
        rises = 0;
      end
      p_sclk = sclk; p_lat = latch; p_busy = busy; p_sdata = sdata;
    end
  end

  task automatic offer(input logic [W-1:0] d, output int waited, output logic [1:0] st);
    if (clk !== 1'b1) @(posedge clk);
    #1;
    data = d;
    valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!ready && waited < 20000) begin
      waited++;
      @(negedge clk);
    end
    check("offer_accepted", ready, 1'b1);
    st = {busy, sclk};
    if (ready) begin
      exp_q.push_back(d);
      n_acc++;
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 6000) begin
      k++;
      @(negedge clk);
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_rises(input int n, input string tag);
    int k;
    k = 0;
    while (rises < n && k < 6000) begin
      k++;
      @(negedge clk);
    end
    check(tag, 64'(rises >= n), 1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || !ready) && k < 15000) begin
      k++;
      @(negedge clk);
    end
    check(tag, {30'd0, busy, ready, 32'(exp_q.size())}, {30'd0, 2'b01, 32'd0});
  endtask

  initial begin
    int           waited, dropped, frames_before;
    int           c8, t8, last8, r8;
    logic [1:0]   st;
    logic [W-1:0] f;
    logic [7:0]   cap8, got8;
    logic         ps8, pl8, pb8, seen8;

    dropped = 0;

    // Reset behaviour, including an asynchronous assertion while idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", {ready, busy, done, latch, sclk, sdata}, 6'b100000);
    check("reset_outputs_w8", {ready8, busy8, done8, latch8, sclk8, sdata8}, 6'b100000);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_no_rises", rises, 0);
    check("idle_not_busy", busy, 1'b0);
    check("idle_ready", ready, 1'b1);

    // Single frame.
    offer(48'hA50F3CFF0081, waited, st);
    check("single_accept_immediate", waited, 0);
    wait_done("single_done_seen");
    check("single_frames", frames, 1);
    check("single_queue_empty", exp_q.size(), 0);

    // Back-to-back frames offered continuously.
    offer(48'h1, waited, st);
    offer(48'h800000000000, waited, st);
    check("b2b_second_in_clk_lo", st, 2'b10);
    check("b2b_third_blocked", ready, 1'b0);
    offer(48'h123456789ABC, waited, st);
    check("b2b_third_waited", 64'(waited > 2000), 1);
    wait_drain("b2b_drained");
    check("b2b_frames", frames, 4);

    // Enable dropped mid-frame with a frame pending.
    offer(48'h0F0F0F0F0F0F, waited, st);
    offer(48'hC3C3C3C3C3C3, waited, st);
    wait_rises(10, "en_reached_bit10");
    en = 1'b0;
    wait_done("en_current_done");
    repeat (200) @(negedge clk);
    check("en_hold_idle", busy, 1'b0);
    check("en_pending_kept", ready, 1'b0);
    check("en_one_queued", exp_q.size(), 1);
    en = 1'b1;
    wait_done("en_pending_done");
    check("en_queue_empty", exp_q.size(), 0);

    // Reset mid-frame with a frame pending.
    frames_before = frames;
    offer(48'h5A5A00FF1234, waited, st);
    offer(48'h0000FFFF0000, waited, st);
    wait_rises(20, "rst_reached_bit20");
    #3 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {ready, busy, done, latch, sclk, sdata}, 6'b100000);
    dropped += exp_q.size();
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_no_latch", frames, frames_before);
    check("rst_pending_dropped", {busy, ready}, 2'b01);
    offer(48'hFFFF_FFFF_FFFF, waited, st);
    wait_done("rst_next_done");
    check("rst_next_frames", frames, frames_before + 1);

    // Randomised frames and spacing.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      f = W'({$urandom, $urandom});
      offer(f, waited, st);
    end
    wait_drain("rand_drained");
    check("rand_frame_count", frames, n_acc - dropped);

    // Narrow configuration: 8 bits, two cycles per phase.
    @(negedge clk);
    check("w8_ready", ready8, 1'b1);
    #1;
    data8 = 8'h81;
    valid8 = 1'b1;
    @(posedge clk);
    #1 valid8 = 1'b0;
    c8 = 0; t8 = -1000; last8 = -1; r8 = 0;
    cap8 = '0; got8 = '0; ps8 = 1'b0; pl8 = 1'b0; pb8 = 1'b0; seen8 = 1'b0;
    for (int k = 0; k < 200 && !seen8; k++) begin
      @(negedge clk);
      c8++;
      if (busy8 && !pb8) t8 = c8;
      if (sclk8 && !ps8) begin
        if (last8 >= 0) check("w8_sclk_period", c8 - last8, 2 * H8);
        last8 = c8;
        cap8 = {cap8[6:0], sdata8};
        r8++;
      end
      if (latch8 && !pl8) got8 = cap8;
      if (done8) begin
        seen8 = 1'b1;
        check("w8_load_to_done", c8 - t8, LAT8);
      end
      ps8 = sclk8; pl8 = latch8; pb8 = busy8;
    end
    check("w8_done_seen", seen8, 1'b1);
    check("w8_capture", got8, 8'h81);
    check("w8_rises", r8, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
